// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: frame geometry, framer state encodings and the
// baud divisor table used by both ends of the link.
package uart_tx_buffered_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_W   = 4;
  localparam int unsigned BIT_CNT_W  = 3;
  localparam int unsigned BAUD_SEL_W = 3;
  localparam int unsigned BAUD_SEL_N = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int unsigned baud_rate(input logic [BAUD_SEL_W-1:0] sel);
    case (sel)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Rounded clk count between 16x sample ticks; only ever evaluated on constants.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input logic [BAUD_SEL_W-1:0] sel);
    int unsigned den;
    den = OVERSAMPLE * baud_rate(sel);
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_baud_controller.sv
// 16x sample tick generator; clear restarts the divider and latches a new
// baud_select so a frame keeps its timing regardless of later changes.
module baud_controller
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [BAUD_SEL_W-1:0] baud_select,
  output logic                  tick
);

  localparam int unsigned DIV_W = $clog2(baud_div(CLK_FREQ, 3'd0) + 1);

  logic [DIV_W-1:0] div_table [BAUD_SEL_N];
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt_reg;

  genvar gi;
  for (gi = 0; gi < BAUD_SEL_N; gi++) begin : g_div
    assign div_table[gi] = DIV_W'(baud_div(CLK_FREQ, 3'(gi)));
  end

  assign tick = (cnt_reg == div_reg - DIV_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= div_table[0];
      cnt_reg <= '0;
    end else if (clear) begin
      div_reg <= div_table[baud_select];
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO in front of a start/8N/even-parity/stop
// framer. A pop happens only from IDLE, so frames are separated by one idle clk.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CLK_FREQ   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     Tx_DATA,
  input  logic                  Tx_WR,
  input  logic                  Tx_EN,
  input  logic [BAUD_SEL_W-1:0] baud_select,
  output logic                  TxD,
  output logic                  Tx_BUSY,
  output logic                  Tx_FULL,
  output logic                  Tx_OVERRUN,
  output logic [3:0]            Tx_COUNT
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [3:0]           count_reg;
  logic                 overrun_reg;
  logic                 fifo_full, fifo_empty, push, pop, drop;

  logic [2:0]           state_reg;
  logic [DATA_W-1:0]    shift_reg;
  logic                 parity_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic [SAMPLE_W-1:0]  sample_cnt_reg;
  logic                 txd_reg;
  logic                 tick, bit_done;

  assign fifo_full  = (count_reg == 4'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == 4'd0);
  assign pop        = (state_reg == ST_IDLE) && Tx_EN && !fifo_empty;
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign push       = Tx_WR && Tx_EN && (!fifo_full || pop);
  assign drop       = Tx_WR && Tx_EN && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= Tx_DATA;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + 4'd1;
      else if (pop && !push) count_reg <= count_reg - 4'd1;
      overrun_reg <= drop;
    end
  end

  baud_controller #(.CLK_FREQ(CLK_FREQ)) u_baud (
    .clk         (clk),
    .reset       (reset),
    .clear       (pop),
    .baud_select (baud_select),
    .tick        (tick)
  );

  assign bit_done = tick && (sample_cnt_reg == SAMPLE_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      bit_cnt_reg    <= '0;
      sample_cnt_reg <= '0;
      txd_reg        <= 1'b1;
    end else if (pop) begin
      shift_reg      <= mem[rd_ptr_reg];
      parity_reg     <= ^mem[rd_ptr_reg];
      bit_cnt_reg    <= '0;
      sample_cnt_reg <= '0;
      txd_reg        <= 1'b0;
      state_reg      <= ST_START;
    end else if (state_reg != ST_IDLE && tick) begin
      sample_cnt_reg <= sample_cnt_reg + SAMPLE_W'(1);
      if (bit_done) begin
        case (state_reg)
          ST_START: begin
            txd_reg   <= shift_reg[0];
            state_reg <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_cnt_reg == BIT_CNT_W'(DATA_W - 1)) begin
              txd_reg   <= parity_reg;
              state_reg <= ST_PARITY;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
              shift_reg   <= shift_reg >> 1;
              txd_reg     <= shift_reg[1];
            end
          end
          ST_PARITY: begin
            txd_reg   <= 1'b1;
            state_reg <= ST_STOP;
          end
          default: begin
            txd_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign TxD        = txd_reg;
  assign Tx_BUSY    = (state_reg != ST_IDLE) || !fifo_empty;
  assign Tx_FULL    = fifo_full;
  assign Tx_OVERRUN = overrun_reg;
  assign Tx_COUNT   = count_reg;

endmodule
